// File: rtl/uv_rsp_route.sv
`default_nettype none
// ============================================================================
//  Module   : uv_rsp_route
//  Brief    : Routes a shared slave response stream back to the requester
//             whose command was granted, using an in-order outstanding FIFO
//             of grant indices and a single registered output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module uv_rsp_route #(
   parameter int CH_NUM     = 2,
   parameter int DAT_WIDTH  = 32,
   parameter int OSTD_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   // downstream command side
   input  logic                          cmd_vld,
   output logic                          cmd_rdy,
   input  logic                          cmd_slv_rdy,
   input  logic [CH_NUM-1:0]             cmd_grant,
   // slave response side
   input  logic                          rsp_vld,
   output logic                          rsp_rdy,
   input  logic [DAT_WIDTH-1:0]          rsp_dat,
   input  logic                          rsp_err,
   // per-channel response side
   output logic [CH_NUM-1:0]             ch_rsp_vld,
   input  logic [CH_NUM-1:0]             ch_rsp_rdy,
   output logic [CH_NUM*DAT_WIDTH-1:0]   ch_rsp_dat,
   output logic [CH_NUM-1:0]             ch_rsp_err,
   // status
   output logic [$clog2(OSTD_DEPTH):0]   ostd_cnt,
   output logic                          orphan
);

   localparam int IDX_W = (CH_NUM > 2) ? $clog2(CH_NUM) : 1;
   localparam int AW    = $clog2(OSTD_DEPTH);
   localparam int PW    = AW + 1;

   // outstanding FIFO state
   logic [IDX_W-1:0] fifo_mem [OSTD_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             empty;
   logic             full;

   // output register state
   logic             out_vld;
   logic [IDX_W-1:0] out_idx;
   logic [DAT_WIDTH-1:0] out_dat;
   logic             out_err;
   logic             orphan_r;

   // handshake and control
   logic [IDX_W-1:0] grant_idx;
   logic             push;
   logic             pop;
   logic             out_free;
   logic             out_taken;

   // Full when the address bits match but the wrap bits differ.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A full FIFO refuses commands even if a pop happens in the same cycle.
   assign cmd_rdy = cmd_slv_rdy & ~full;

   // An all-zero grant completes the handshake but records nothing.
   assign push = cmd_vld & cmd_rdy & (|cmd_grant);

   // Output stage can take new data when empty or being drained this cycle.
   assign out_taken = out_vld & ch_rsp_rdy[out_idx];
   assign out_free  = ~out_vld | ch_rsp_rdy[out_idx];

   // With nothing outstanding, responses are always accepted and dropped.
   assign rsp_rdy = empty | out_free;
   assign pop     = rsp_vld & ~empty & out_free;

   assign ostd_cnt = wr_ptr - rd_ptr;
   assign orphan   = orphan_r;

   // Lowest set bit of the one-hot grant becomes the stored channel index.
   always_comb begin
      grant_idx = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (cmd_grant[i]) begin
            grant_idx = i[IDX_W-1:0];
         end
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= grant_idx;
      end
   end

   // FIFO pointers advance on push/pop and wrap at twice the depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Registered output stage: load on accept, clear once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_idx <= '0;
         out_dat <= '0;
         out_err <= 1'b0;
      end else if (pop) begin
         out_vld <= 1'b1;
         out_idx <= fifo_mem[rd_ptr[AW-1:0]];
         out_dat <= rsp_dat;
         out_err <= rsp_err;
      end else if (out_taken) begin
         out_vld <= 1'b0;
      end
   end

   // Orphan pulse flags a response that arrived with nothing outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         orphan_r <= 1'b0;
      end else begin
         orphan_r <= rsp_vld & empty;
      end
   end

   // Valid is steered per channel; data and error are broadcast to all lanes.
   generate
      for (genvar g = 0; g < CH_NUM; g++) begin : g_ch_lane
         assign ch_rsp_vld[g]                           = out_vld && (out_idx == g[IDX_W-1:0]);
         assign ch_rsp_dat[g*DAT_WIDTH +: DAT_WIDTH]    = out_dat;
         assign ch_rsp_err[g]                           = out_err;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uv_rsp_route.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uv_rsp_route
//  Brief    : Self-checking bench for uv_rsp_route (CH_NUM=2, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uv_rsp_route;

   localparam int CH_NUM     = 2;
   localparam int DAT_WIDTH  = 32;
   localparam int OSTD_DEPTH = 4;

   logic                        clk;
   logic                        rst;
   logic                        cmd_vld;
   logic                        cmd_rdy;
   logic                        cmd_slv_rdy;
   logic [CH_NUM-1:0]           cmd_grant;
   logic                        rsp_vld;
   logic                        rsp_rdy;
   logic [DAT_WIDTH-1:0]        rsp_dat;
   logic                        rsp_err;
   logic [CH_NUM-1:0]           ch_rsp_vld;
   logic [CH_NUM-1:0]           ch_rsp_rdy;
   logic [CH_NUM*DAT_WIDTH-1:0] ch_rsp_dat;
   logic [CH_NUM-1:0]           ch_rsp_err;
   logic [2:0]                  ostd_cnt;
   logic                        orphan;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int                   idx;
      logic [DAT_WIDTH-1:0] dat;
      logic                 err;
   } exp_t;

   exp_t exp_q[$];   // responses expected at channel outputs, in order
   int   ostd_q[$];  // model of outstanding grant indices

   uv_rsp_route #(
      .CH_NUM     (CH_NUM),
      .DAT_WIDTH  (DAT_WIDTH),
      .OSTD_DEPTH (OSTD_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_vld     (cmd_vld),
      .cmd_rdy     (cmd_rdy),
      .cmd_slv_rdy (cmd_slv_rdy),
      .cmd_grant   (cmd_grant),
      .rsp_vld     (rsp_vld),
      .rsp_rdy     (rsp_rdy),
      .rsp_dat     (rsp_dat),
      .rsp_err     (rsp_err),
      .ch_rsp_vld  (ch_rsp_vld),
      .ch_rsp_rdy  (ch_rsp_rdy),
      .ch_rsp_dat  (ch_rsp_dat),
      .ch_rsp_err  (ch_rsp_err),
      .ostd_cnt    (ostd_cnt),
      .orphan      (orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int low_idx(input logic [CH_NUM-1:0] g);
      for (int i = 0; i < CH_NUM; i++) begin
         if (g[i]) return i;
      end
      return -1;
   endfunction

   // Scoreboard monitor at the falling edge: consume, then record new accepts.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         ostd_q.delete();
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (ch_rsp_vld[i] && ch_rsp_rdy[i]) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected: ch%0d delivered %h, required no delivery", i,
                           ch_rsp_dat[i*DAT_WIDTH +: DAT_WIDTH]);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (e.idx != i || ch_rsp_dat[i*DAT_WIDTH +: DAT_WIDTH] !== e.dat ||
                      ch_rsp_err[i] !== e.err) begin
                     n_fail++;
                     $display("FAIL sb_data: got ch%0d dat=%h err=%b, required ch%0d dat=%h err=%b",
                              i, ch_rsp_dat[i*DAT_WIDTH +: DAT_WIDTH], ch_rsp_err[i],
                              e.idx, e.dat, e.err);
                  end
               end
            end
         end
         if (rsp_vld && rsp_rdy && ostd_q.size() != 0) begin
            exp_t n;
            n.idx = ostd_q.pop_front();
            n.dat = rsp_dat;
            n.err = rsp_err;
            exp_q.push_back(n);
         end
         if (cmd_vld && cmd_rdy && cmd_grant != '0) begin
            ostd_q.push_back(low_idx(cmd_grant));
         end
      end
   end

   // Advance one cycle; inputs are driven 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_vld   = 1'b0;
      cmd_grant = '0;
      rsp_vld   = 1'b0;
      rsp_dat   = '0;
      rsp_err   = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      cmd_slv_rdy = 1'b1;
      ch_rsp_rdy  = 2'b11;
      idle_inputs();
      step(); step();
      rst = 1'b0;
      step(); #1;
      n_checks++; if (ch_rsp_vld !== 2'b00) begin n_fail++; $display("FAIL rst_vld: got %b required 00", ch_rsp_vld); end
      n_checks++; if (ostd_cnt !== 3'd0)    begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", ostd_cnt); end
      n_checks++; if (rsp_rdy !== 1'b1)     begin n_fail++; $display("FAIL rst_rsp_rdy: got %b required 1", rsp_rdy); end
      n_checks++; if (cmd_rdy !== 1'b1)     begin n_fail++; $display("FAIL rst_cmd_rdy: got %b required 1", cmd_rdy); end
      n_checks++; if (orphan !== 1'b0)      begin n_fail++; $display("FAIL rst_orphan: got %b required 0", orphan); end
   endtask

   task automatic test_route();
      logic [1:0]  grants [3];
      logic [31:0] dats   [3];
      grants[0] = 2'b01; grants[1] = 2'b10; grants[2] = 2'b10;
      dats[0] = 32'hA; dats[1] = 32'hB; dats[2] = 32'hC;
      ch_rsp_rdy = 2'b11;
      for (int k = 0; k < 3; k++) begin
         step(); cmd_vld = 1'b1; cmd_grant = grants[k];
      end
      step(); idle_inputs(); #1;
      n_checks++; if (ostd_cnt !== 3'd3) begin n_fail++; $display("FAIL route_cnt3: got %0d required 3", ostd_cnt); end
      for (int k = 0; k < 3; k++) begin
         step(); rsp_vld = 1'b1; rsp_dat = dats[k]; rsp_err = (k == 1); #1;
         n_checks++; if (rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL route_rsp_rdy%0d: got %b required 1", k, rsp_rdy); end
         if (k == 1) begin
            n_checks++;
            if (ch_rsp_vld !== 2'b01 || ch_rsp_dat[31:0] !== 32'hA) begin
               n_fail++; $display("FAIL route_t1: got vld=%b dat=%h required vld=01 dat=a", ch_rsp_vld, ch_rsp_dat[31:0]);
            end
         end
         if (k == 2) begin
            n_checks++;
            if (ch_rsp_vld !== 2'b10 || ch_rsp_dat[63:32] !== 32'hB || ch_rsp_err !== 2'b11) begin
               n_fail++; $display("FAIL route_t2: got vld=%b dat=%h err=%b required vld=10 dat=b err=11", ch_rsp_vld, ch_rsp_dat[63:32], ch_rsp_err);
            end
         end
      end
      step(); idle_inputs(); #1;
      n_checks++;
      if (ch_rsp_vld !== 2'b10 || ch_rsp_dat[63:32] !== 32'hC) begin
         n_fail++; $display("FAIL route_t3: got vld=%b dat=%h required vld=10 dat=c", ch_rsp_vld, ch_rsp_dat[63:32]);
      end
      step(); #1;
      n_checks++; if (ch_rsp_vld !== 2'b00) begin n_fail++; $display("FAIL route_drain_vld: got %b required 00", ch_rsp_vld); end
      n_checks++; if (ostd_cnt !== 3'd0)    begin n_fail++; $display("FAIL route_drain_cnt: got %0d required 0", ostd_cnt); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         step(); cmd_vld = 1'b1; cmd_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
      end
      step(); cmd_vld = 1'b1; cmd_grant = 2'b01; #1;
      n_checks++; if (ostd_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt: got %0d required 4", ostd_cnt); end
      n_checks++; if (cmd_rdy !== 1'b0)  begin n_fail++; $display("FAIL full_cmd_rdy: got %b required 0", cmd_rdy); end
      // pop and command in the same cycle while full: command still refused
      step(); cmd_vld = 1'b1; cmd_grant = 2'b10; rsp_vld = 1'b1; rsp_dat = 32'h100; #1;
      n_checks++; if (cmd_rdy !== 1'b0)  begin n_fail++; $display("FAIL full_same_cycle: got cmd_rdy=%b required 0", cmd_rdy); end
      step(); rsp_vld = 1'b0; #1;
      n_checks++; if (ostd_cnt !== 3'd3 || cmd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL full_refill: got cnt=%0d cmd_rdy=%b required cnt=3 cmd_rdy=1", ostd_cnt, cmd_rdy);
      end
      step(); idle_inputs(); #1;
      n_checks++; if (ostd_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt_again: got %0d required 4", ostd_cnt); end
      for (int k = 0; k < 4; k++) begin
         step(); rsp_vld = 1'b1; rsp_dat = 32'h200 + k; rsp_err = k[0];
      end
      step(); idle_inputs();
      step(); step(); #1;
      n_checks++; if (ostd_cnt !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d required 0", ostd_cnt); end
   endtask

   task automatic test_backpressure();
      ch_rsp_rdy = 2'b01;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b10;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b10;
      step(); idle_inputs(); rsp_vld = 1'b1; rsp_dat = 32'hD1;
      for (int k = 0; k < 3; k++) begin
         step(); rsp_vld = 1'b1; rsp_dat = 32'hD2; #1;
         n_checks++;
         if (rsp_rdy !== 1'b0 || ch_rsp_vld !== 2'b10 || ch_rsp_dat[63:32] !== 32'hD1) begin
            n_fail++; $display("FAIL bp_hold%0d: got rsp_rdy=%b vld=%b dat=%h required 0 10 d1", k, rsp_rdy, ch_rsp_vld, ch_rsp_dat[63:32]);
         end
      end
      step(); ch_rsp_rdy = 2'b11; #1;
      n_checks++; if (rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release: got rsp_rdy=%b required 1", rsp_rdy); end
      step(); idle_inputs(); #1;
      n_checks++;
      if (ch_rsp_vld !== 2'b10 || ch_rsp_dat[63:32] !== 32'hD2) begin
         n_fail++; $display("FAIL bp_second: got vld=%b dat=%h required 10 d2", ch_rsp_vld, ch_rsp_dat[63:32]);
      end
      step(); #1;
      n_checks++; if (ch_rsp_vld !== 2'b00 || ostd_cnt !== 3'd0) begin
         n_fail++; $display("FAIL bp_done: got vld=%b cnt=%0d required 00 0", ch_rsp_vld, ostd_cnt);
      end
   endtask

   task automatic test_orphan();
      step(); rsp_vld = 1'b1; rsp_dat = 32'hDEAD; #1;
      n_checks++; if (rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL orph_rdy: got %b required 1", rsp_rdy); end
      step(); idle_inputs(); #1;
      n_checks++; if (orphan !== 1'b1 || ch_rsp_vld !== 2'b00) begin
         n_fail++; $display("FAIL orph_pulse: got orphan=%b vld=%b required 1 00", orphan, ch_rsp_vld);
      end
      step(); #1;
      n_checks++; if (orphan !== 1'b0) begin n_fail++; $display("FAIL orph_clear: got %b required 0", orphan); end
   endtask

   task automatic test_push_pop();
      step(); cmd_vld = 1'b1; cmd_grant = 2'b01;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b10; rsp_vld = 1'b1; rsp_dat = 32'h55; #1;
      n_checks++; if (ostd_cnt !== 3'd1) begin n_fail++; $display("FAIL pp_pre: got %0d required 1", ostd_cnt); end
      step(); idle_inputs(); #1;
      n_checks++; if (ostd_cnt !== 3'd1 || ch_rsp_vld !== 2'b01) begin
         n_fail++; $display("FAIL pp_post: got cnt=%0d vld=%b required 1 01", ostd_cnt, ch_rsp_vld);
      end
      step(); rsp_vld = 1'b1; rsp_dat = 32'h66;
      // an all-zero grant handshakes but records nothing
      step(); idle_inputs(); cmd_vld = 1'b1; cmd_grant = 2'b00; #1;
      n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL zg_rdy: got %b required 1", cmd_rdy); end
      step(); idle_inputs(); step(); #1;
      n_checks++; if (ostd_cnt !== 3'd0) begin n_fail++; $display("FAIL zg_cnt: got %0d required 0", ostd_cnt); end
   endtask

   task automatic test_reset_mid();
      ch_rsp_rdy = 2'b00;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b01;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b10;
      step(); cmd_vld = 1'b1; cmd_grant = 2'b01;
      step(); idle_inputs(); rsp_vld = 1'b1; rsp_dat = 32'h77;
      step(); idle_inputs(); #1;
      n_checks++; if (ostd_cnt !== 3'd2 || ch_rsp_vld !== 2'b01) begin
         n_fail++; $display("FAIL rm_pre: got cnt=%0d vld=%b required 2 01", ostd_cnt, ch_rsp_vld);
      end
      step(); rst = 1'b1;
      step(); rst = 1'b0; ch_rsp_rdy = 2'b11; #1;
      n_checks++;
      if (ostd_cnt !== 3'd0 || ch_rsp_vld !== 2'b00 || cmd_rdy !== cmd_slv_rdy || rsp_rdy !== 1'b1 || orphan !== 1'b0) begin
         n_fail++; $display("FAIL rm_post: got cnt=%0d vld=%b cmd_rdy=%b rsp_rdy=%b orphan=%b required 0 00 1 1 0",
                            ostd_cnt, ch_rsp_vld, cmd_rdy, rsp_rdy, orphan);
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_full();
      test_backpressure();
      test_orphan();
      test_push_pop();
      test_reset_mid();
      step(); step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: got %0d pending responses required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
